// File: rtl/axis_forwarder_pkg.sv
// Shared widths, read latency, output FIFO depth and FSM encoding for the forwarder.
// Latency: n/a (compile-time constants and helpers only).
// Backpressure: n/a.
package axis_forwarder_pkg;

    // Forwarder FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fwd_state_e;

    // Memory word width in bits: bytes per word times eight
    function automatic int calc_dw(input int pbaw, input int sfaw);
        return 1 << (3 + pbaw - sfaw);
    endfunction

    // Packet length width: one extra bit so a full buffer length is representable
    function automatic int calc_lw(input int sfaw);
        return sfaw + 1;
    endfunction

    // Packet memory read latency in cycles
    function automatic int calc_lat(input int pessimistic);
        return (pessimistic != 0) ? 2 : 1;
    endfunction

    // Output FIFO depth: enough credits to cover the read latency plus the registered output
    function automatic int calc_fifo_depth(input int pessimistic);
        return calc_lat(pessimistic) + 2;
    endfunction

endpackage

// File: rtl/axis_forwarder_if.sv
// AXI-Stream bundle carrying forwarded packet words out of the block.
// Latency: n/a (wiring only).
// Backpressure: tready from the slave side stalls the master.
interface axis_forwarder_if #(
    parameter int DW = 64
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_forwarder_fifo.sv
// Small synchronous FIFO with registered storage feeding the stream output directly.
// Latency: a word pushed in cycle N is visible at the output in cycle N+1.
// Backpressure: rd_rdy_i low holds the head word; writer must respect cnt_o (push when full is illegal).
module fwd_out_fifo #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 65,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_rdy_i,
    output logic             rd_vld_o,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic [CW-1:0]    cnt_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en, rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_vld_o = (cnt_q != '0);
    assign rd_en    = rd_vld_o & rd_rdy_i;
    assign wr_en    = wr_vld_i;
    assign cnt_o    = cnt_q;
    // Empty FIFO presents zeros so the stream outputs are clean when idle or in reset
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents need no reset because occupancy gates the output
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        wr_vld_i |-> ((cnt_q < CW'(DEPTH)) || rd_en));

endmodule

// File: rtl/axis_forwarder.sv
// Streams a dispatched packet buffer out of packet memory as an AXI-Stream master, then releases it.
// Latency: first beat L+2 cycles after ready_for_forwarder is sampled; 1 beat/cycle sustained.
// Backpressure: reads are credit-limited to the output FIFO depth, so tready stalls never lose data.
module axis_forwarder
    import axis_forwarder_pkg::*;
#(
    parameter  int PACKET_BYTE_ADDR_WIDTH = 12,
    parameter  int SNOOP_FWD_ADDR_WIDTH   = 9,
    parameter  int PESSIMISTIC            = 0,
    localparam int DW = calc_dw(PACKET_BYTE_ADDR_WIDTH, SNOOP_FWD_ADDR_WIDTH),
    localparam int LW = calc_lw(SNOOP_FWD_ADDR_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ready_for_forwarder,
    input  logic [LW-1:0]                   len_to_forwarder,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                            forwarder_rd_en,
    input  logic [DW-1:0]                   forwarder_rd_data,
    output logic                            forwarder_done,
    axis_forwarder_if.master                m_axis
);

    localparam int L          = calc_lat(PESSIMISTIC);
    localparam int FIFO_DEPTH = calc_fifo_depth(PESSIMISTIC);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    localparam logic [LW-1:0] MAX_LEN = {1'b1, {SNOOP_FWD_ADDR_WIDTH{1'b0}}};
    localparam logic [LW-1:0] ONE     = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   CREDITS = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } beat_t;

    fwd_state_e    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [L-1:0]  vld_pipe_q, vld_pipe_d;
    logic [L-1:0]  tag_pipe_q, tag_pipe_d;
    logic          last_seen_q, last_seen_d;

    logic [LW-1:0] len_clamped;
    logic [CW-1:0] fifo_cnt;
    logic          credit_ok;
    logic          issue;
    logic          issue_last;
    logic          ret;
    logic          out_vld;
    logic          pop;
    logic          last_hs;
    logic          fifo_will_empty;
    beat_t         push_beat;
    beat_t         pop_beat;

    // A buffer never holds more than 2^SNOOP_FWD_ADDR_WIDTH words, so longer lengths are clamped
    assign len_clamped = (len_to_forwarder > MAX_LEN) ? MAX_LEN : len_to_forwarder;

    // Issue only while FIFO occupancy plus reads in flight leaves a free slot for the return
    assign credit_ok  = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < CREDITS;
    assign issue      = (state_q == ST_READ) && credit_ok && (rd_cnt_q < len_q);
    assign issue_last = (rd_cnt_q == (len_q - ONE));
    assign ret        = vld_pipe_q[L-1];

    assign push_beat.last = tag_pipe_q[L-1];
    assign push_beat.dat  = forwarder_rd_data;

    assign pop             = out_vld & m_axis.tready;
    assign last_hs         = pop & pop_beat.last;
    assign fifo_will_empty = (fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop);

    assign forwarder_rd_en   = issue;
    assign forwarder_rd_addr = issue ? rd_cnt_q[SNOOP_FWD_ADDR_WIDTH-1:0] : '0;
    assign forwarder_done    = (state_q == ST_DONE);

    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = pop_beat.dat;
    assign m_axis.tlast  = pop_beat.last;

    // FSM next-state: latch length, issue reads, wait for the last beat, pulse done
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        last_seen_d = last_seen_q;
        if (last_hs) begin
            last_seen_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (ready_for_forwarder) begin
                    len_d       = len_clamped;
                    rd_cnt_d    = '0;
                    last_seen_d = 1'b0;
                    state_d     = (len_clamped == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + ONE;
                    if ((rd_cnt_q + ONE) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the tlast handshake itself so done follows it by one cycle
                if ((inflight_q == '0) && fifo_will_empty && (last_seen_q || last_hs)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read tag pipe and in-flight count: valid/tlast travel alongside the memory latency
    always_comb begin
        vld_pipe_d    = '0;
        tag_pipe_d    = '0;
        vld_pipe_d[0] = issue;
        tag_pipe_d[0] = issue & issue_last;
        for (int i = 1; i < L; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
        case ({issue, ret})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State, counters and tag pipe registers; reset discards any reads in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            inflight_q  <= '0;
            vld_pipe_q  <= '0;
            tag_pipe_q  <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            inflight_q  <= inflight_d;
            vld_pipe_q  <= vld_pipe_d;
            tag_pipe_q  <= tag_pipe_d;
            last_seen_q <= last_seen_d;
        end
    end

    fwd_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld_i (ret),
        .wr_dat_i (push_beat),
        .rd_rdy_i (m_axis.tready),
        .rd_vld_o (out_vld),
        .rd_dat_o (pop_beat),
        .cnt_o    (fifo_cnt)
    );

endmodule

// File: tb/tb_axis_forwarder.sv
// Directed bench: two forwarders (L=1 and L=2) against latency-accurate memory models.
// Latency: n/a.
// Backpressure: tready toggled on the L=1 instance, held high on the L=2 instance.
`timescale 1ns/1ps
module tb_axis_forwarder;

    localparam int AW = 9;
    localparam int LW = 10;
    localparam int DW = 64;
    localparam int NB = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          rdy0, rdy1;
    logic [LW-1:0] len0, len1;
    logic          tready0;
    logic [AW-1:0] addr0, addr1;
    logic          ren0, ren1;
    logic [DW-1:0] rdat0, rdat1;
    logic          done0, done1;
    logic          bank1;

    axis_forwarder_if #(.DW(DW)) ax0 ();
    axis_forwarder_if #(.DW(DW)) ax1 ();
    assign ax0.tready = tready0;
    assign ax1.tready = 1'b1;

    axis_forwarder #(
        .PACKET_BYTE_ADDR_WIDTH (12),
        .SNOOP_FWD_ADDR_WIDTH   (9),
        .PESSIMISTIC            (0)
    ) dut0 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ready_for_forwarder (rdy0),
        .len_to_forwarder    (len0),
        .forwarder_rd_addr   (addr0),
        .forwarder_rd_en     (ren0),
        .forwarder_rd_data   (rdat0),
        .forwarder_done      (done0),
        .m_axis              (ax0)
    );

    axis_forwarder #(
        .PACKET_BYTE_ADDR_WIDTH (12),
        .SNOOP_FWD_ADDR_WIDTH   (9),
        .PESSIMISTIC            (1)
    ) dut1 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ready_for_forwarder (rdy1),
        .len_to_forwarder    (len1),
        .forwarder_rd_addr   (addr1),
        .forwarder_rd_en     (ren1),
        .forwarder_rd_data   (rdat1),
        .forwarder_done      (done1),
        .m_axis              (ax1)
    );

    // Packet memory models: one-cycle read for dut0, two-cycle read for dut1
    logic [DW-1:0] mem0 [0:511];
    logic [DW-1:0] mem1 [0:1023];
    logic [DW-1:0] m1_s1;

    always @(posedge clk) begin
        if (ren0) rdat0 <= mem0[addr0];
        if (ren1) m1_s1 <= mem1[{bank1, addr1}];
        rdat1 <= m1_s1;
    end

    // Dispatcher model for dut1: swap buffer and length on each done pulse
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank1 <= 1'b0;
        else if (done1) bank1 <= ~bank1;
    end
    assign len1 = bank1 ? 10'd2 : 10'd4;

    // Per-instance views for the monitor
    logic          tv [2];
    logic          tr [2];
    logic          tl [2];
    logic          re [2];
    logic          dw [2];
    logic [DW-1:0] td [2];
    logic [AW-1:0] ad [2];
    assign tv[0] = ax0.tvalid; assign tv[1] = ax1.tvalid;
    assign tr[0] = ax0.tready; assign tr[1] = ax1.tready;
    assign tl[0] = ax0.tlast;  assign tl[1] = ax1.tlast;
    assign td[0] = ax0.tdata;  assign td[1] = ax1.tdata;
    assign re[0] = ren0;       assign re[1] = ren1;
    assign ad[0] = addr0;      assign ad[1] = addr1;
    assign dw[0] = done0;      assign dw[1] = done1;

    logic [DW-1:0] bdat [2][NB];
    logic          blast[2][NB];
    int            bcyc [2][NB];
    logic [AW-1:0] alog [2][NB];
    int            bn [2];
    int            an [2];
    int            dn [2];
    int            dcyc [2];
    int            serr [2];
    int            cyc;
    logic          pstall [2];
    logic [DW-1:0] pdat [2];
    logic          plast [2];

    // Monitor on the falling edge: beats, read addresses, done pulses, stall stability
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && pstall[d] && !(tv[d] && td[d] == pdat[d] && tl[d] == plast[d]))
                serr[d] = serr[d] + 1;
            if (tv[d] && tr[d]) begin
                bdat[d][bn[d] % NB]  = td[d];
                blast[d][bn[d] % NB] = tl[d];
                bcyc[d][bn[d] % NB]  = cyc;
                bn[d] = bn[d] + 1;
            end
            if (re[d]) begin
                alog[d][an[d] % NB] = ad[d];
                an[d] = an[d] + 1;
            end
            if (dw[d]) begin
                dn[d]   = dn[d] + 1;
                dcyc[d] = cyc;
            end
            pstall[d] = rst_n && tv[d] && !tr[d];
            pdat[d]   = td[d];
            plast[d]  = tl[d];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one buffer to dut0 for a single sampling edge; s is the stamp of that cycle
    task automatic start0(input logic [LW-1:0] len, output int s);
        len0 = len;
        rdy0 = 1'b1;
        s    = cyc + 1;
        tick();
        rdy0 = 1'b0;
    endtask

    task automatic wait_done0(input int target, input string tag);
        int n = 0;
        while (dn[0] < target && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 64'(dn[0] >= target), 64'd1);
    endtask

    int b, a, dd, s, se, errs, nl, n;

    initial begin
        rst_n   = 1'b0;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        len0    = '0;
        tready0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bn[i] = 0; an[i] = 0; dn[i] = 0; dcyc[i] = 0; serr[i] = 0; pstall[i] = 1'b0;
        end
        cyc = 0;
        for (int i = 0; i < 512; i++) begin
            mem0[i]       = 64'hABCD_0000_0000_0000 + 64'(i);
            mem1[i]       = 64'h5000 + 64'(i);
            mem1[512 + i] = 64'h6000 + 64'(i);
        end
        repeat (3) tick();

        // Reset state
        chk("rst_tvalid0", 64'(ax0.tvalid), 64'd0);
        chk("rst_tdata0",  ax0.tdata, 64'd0);
        chk("rst_tlast0",  64'(ax0.tlast), 64'd0);
        chk("rst_rden0",   64'(ren0), 64'd0);
        chk("rst_done0",   64'(done0), 64'd0);
        chk("rst_tvalid1", 64'(ax1.tvalid), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // len=3, tready=1
        for (int i = 0; i < 8; i++) mem0[i] = 64'h1000 + 64'(i);
        b = bn[0]; a = an[0]; dd = dn[0];
        start0(10'd3, s);
        wait_done0(dd + 1, "t1_timeout");
        repeat (3) tick();
        chk("t1_nbeats", 64'(bn[0] - b), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk("t1_data", bdat[0][(b + k) % NB], 64'h1000 + 64'(k));
            chk("t1_last", 64'(blast[0][(b + k) % NB]), 64'(k == 2));
            chk("t1_addr", 64'(alog[0][(a + k) % NB]), 64'(k));
        end
        chk("t1_naddr",   64'(an[0] - a), 64'd3);
        chk("t1_b2b",     64'(bcyc[0][(b + 2) % NB] - bcyc[0][b % NB]), 64'd2);
        chk("t1_latency", 64'((bcyc[0][b % NB] - s) <= 4), 64'd1);
        chk("t1_ndone",   64'(dn[0] - dd), 64'd1);
        chk("t1_donecyc", 64'(dcyc[0] - bcyc[0][(b + 2) % NB]), 64'd1);

        // len=5, tready toggling
        for (int i = 0; i < 8; i++) mem0[i] = 64'h2000 + 64'(i);
        b = bn[0]; dd = dn[0]; se = serr[0];
        start0(10'd5, s);
        n = 0;
        while (dn[0] < dd + 1 && n < 200) begin
            tready0 = ~tready0;
            tick();
            n++;
        end
        tready0 = 1'b1;
        chk("t2_timeout", 64'(dn[0] >= dd + 1), 64'd1);
        repeat (3) tick();
        chk("t2_nbeats", 64'(bn[0] - b), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk("t2_data", bdat[0][(b + k) % NB], 64'h2000 + 64'(k));
            chk("t2_last", 64'(blast[0][(b + k) % NB]), 64'(k == 4));
        end
        chk("t2_stalled", 64'((bcyc[0][(b + 4) % NB] - bcyc[0][b % NB]) > 4), 64'd1);
        chk("t2_stable",  64'(serr[0] - se), 64'd0);
        chk("t2_ndone",   64'(dn[0] - dd), 64'd1);

        // len=0
        b = bn[0]; a = an[0]; dd = dn[0];
        start0(10'd0, s);
        wait_done0(dd + 1, "t3_timeout");
        repeat (4) tick();
        chk("t3_nbeats",  64'(bn[0] - b), 64'd0);
        chk("t3_naddr",   64'(an[0] - a), 64'd0);
        chk("t3_ndone",   64'(dn[0] - dd), 64'd1);
        chk("t3_donecyc", 64'(dcyc[0] - s), 64'd1);

        // len=512 then len=513 (clamped to 512)
        for (int i = 0; i < 512; i++) mem0[i] = 64'hABCD_0000_0000_0000 + 64'(i);
        for (int t = 0; t < 2; t++) begin
            b = bn[0]; a = an[0]; dd = dn[0];
            start0((t == 0) ? 10'd512 : 10'd513, s);
            wait_done0(dd + 1, "t4_timeout");
            repeat (3) tick();
            errs = 0; nl = 0;
            for (int k = 0; k < 512; k++) begin
                if (bdat[0][(b + k) % NB] !== (64'hABCD_0000_0000_0000 + 64'(k))) errs++;
                if (blast[0][(b + k) % NB]) nl++;
            end
            chk("t4_nbeats",   64'(bn[0] - b), 64'd512);
            chk("t4_data",     64'(errs), 64'd0);
            chk("t4_nlast",    64'(nl), 64'd1);
            chk("t4_lastpos",  64'(blast[0][(b + 511) % NB]), 64'd1);
            chk("t4_naddr",    64'(an[0] - a), 64'd512);
            chk("t4_lastaddr", 64'(alog[0][(an[0] - 1) % NB]), 64'd511);
            chk("t4_rate",     64'(bcyc[0][(b + 511) % NB] - bcyc[0][b % NB]), 64'd511);
        end

        // Reset after 2 of 6 beats, then a clean len=2 packet
        for (int i = 0; i < 8; i++) mem0[i] = 64'h3000 + 64'(i);
        b = bn[0]; dd = dn[0];
        start0(10'd6, s);
        n = 0;
        while (bn[0] - b < 2 && n < 50) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 64'(ax0.tvalid), 64'd0);
        chk("t5_rst_tdata",  ax0.tdata, 64'd0);
        chk("t5_rst_tlast",  64'(ax0.tlast), 64'd0);
        chk("t5_rst_rden",   64'(ren0), 64'd0);
        chk("t5_rst_addr",   64'(addr0), 64'd0);
        chk("t5_rst_done",   64'(done0), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t5_nbeats", 64'(bn[0] - b), 64'd2);
        chk("t5_ndone",  64'(dn[0] - dd), 64'd0);
        chk("t5_data0",  bdat[0][b % NB], 64'h3000);
        chk("t5_data1",  bdat[0][(b + 1) % NB], 64'h3001);
        for (int i = 0; i < 8; i++) mem0[i] = 64'h4000 + 64'(i);
        b = bn[0]; a = an[0]; dd = dn[0];
        start0(10'd2, s);
        wait_done0(dd + 1, "t5_timeout");
        repeat (3) tick();
        chk("t5b_nbeats", 64'(bn[0] - b), 64'd2);
        for (int k = 0; k < 2; k++) begin
            chk("t5b_data", bdat[0][(b + k) % NB], 64'h4000 + 64'(k));
            chk("t5b_last", 64'(blast[0][(b + k) % NB]), 64'(k == 1));
            chk("t5b_addr", 64'(alog[0][(a + k) % NB]), 64'(k));
        end
        chk("t5b_naddr", 64'(an[0] - a), 64'd2);
        chk("t5b_ndone", 64'(dn[0] - dd), 64'd1);

        // L=2, ready held across two buffers: len=4 (0x5000..) then len=2 (0x6000..)
        b = bn[1]; a = an[1]; dd = dn[1];
        rdy1 = 1'b1;
        s = cyc + 1;
        n = 0;
        while (dn[1] < dd + 2 && n < 200) begin
            tick();
            n++;
        end
        rdy1 = 1'b0;
        chk("t6_timeout", 64'(dn[1] >= dd + 2), 64'd1);
        repeat (5) tick();
        chk("t6_nbeats", 64'(bn[1] - b), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk("t6_data", bdat[1][(b + k) % NB],
                (k < 4) ? 64'h5000 + 64'(k) : 64'h6000 + 64'(k - 4));
            chk("t6_last", 64'(blast[1][(b + k) % NB]), 64'(k == 3 || k == 5));
            chk("t6_addr", 64'(alog[1][(a + k) % NB]), (k < 4) ? 64'(k) : 64'(k - 4));
        end
        chk("t6_naddr",   64'(an[1] - a), 64'd6);
        chk("t6_rate_a",  64'(bcyc[1][(b + 3) % NB] - bcyc[1][b % NB]), 64'd3);
        chk("t6_rate_b",  64'(bcyc[1][(b + 5) % NB] - bcyc[1][(b + 4) % NB]), 64'd1);
        chk("t6_latency", 64'((bcyc[1][b % NB] - s) <= 5), 64'd1);
        chk("t6_ndone",   64'(dn[1] - dd), 64'd2);
        chk("t6_donecyc", 64'(dcyc[1] - bcyc[1][(b + 5) % NB]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
